// File: rtl/fft_bitrev_stream_if.sv
// Stream bundle for fft_bitrev_stream: natural-order input and bit-reversed output
// handshakes, plus the framing error pulse.
interface fft_bitrev_stream_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic [2*DATA_WIDTH-1:0] in_data;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_ready;
  logic [2*DATA_WIDTH-1:0] out_data;
  logic                    out_valid;
  logic                    out_first;
  logic                    out_last;
  logic                    out_ready;
  logic                    frame_err;

  // Upstream/downstream side (drives samples in, accepts samples out)
  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_first, out_last, frame_err
  );

  // Reorder block side
  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_first, out_last, frame_err
  );
endinterface

// File: rtl/fft_bitrev_stream.sv
// fft_bitrev_stream: buffers N-sample complex frames in a ping-pong register bank,
// writing in natural order and reading back in bit-reversed index order.
module fft_bitrev_stream #(
  parameter int unsigned N          = 16,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  fft_bitrev_stream_if.slave bus
);
  localparam int unsigned   AW       = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned   SW       = 2 * DATA_WIDTH;
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  logic [SW-1:0] mem_q [2][N];

  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] wr_cnt_q,  wr_cnt_d;
  logic [AW-1:0] rd_cnt_q,  rd_cnt_d;
  logic [1:0]    full_q,    full_d;
  logic          frame_err_q, frame_err_d;

  logic          in_ready;
  logic          out_valid;
  logic          in_xfer;
  logic          out_xfer;
  logic [AW-1:0] rd_addr;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < AW; i++) begin
      r[i] = a[AW-1-i];
    end
    return r;
  endfunction

  // Handshake qualifiers and read address
  always_comb begin
    in_ready  = !rst && !full_q[wr_bank_q];
    out_valid = full_q[rd_bank_q];
    in_xfer   = bus.in_valid && in_ready;
    out_xfer  = out_valid && bus.out_ready;
    rd_addr   = bitrev(rd_cnt_q);
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = mem_q[rd_bank_q][rd_addr];
  assign bus.out_first = out_valid && (rd_cnt_q == '0);
  assign bus.out_last  = out_valid && (rd_cnt_q == LAST_IDX);
  assign bus.frame_err = frame_err_q;

  // Next-state for counters, bank pointers and full flags; write and read sides
  // always target different banks, so their full updates never collide
  always_comb begin
    wr_bank_d   = wr_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_bank_d   = rd_bank_q;
    rd_cnt_d    = rd_cnt_q;
    full_d      = full_q;
    frame_err_d = 1'b0;

    if (in_xfer) begin
      frame_err_d = bus.in_last != (wr_cnt_q == LAST_IDX);
      if (wr_cnt_q == LAST_IDX) begin
        wr_cnt_d          = '0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end

    if (out_xfer) begin
      if (rd_cnt_q == LAST_IDX) begin
        rd_cnt_d          = '0;
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end
  end

  // Control state registers; reset discards any partial or buffered frames
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      full_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      full_q      <= full_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Sample storage; contents are not reset
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      mem_q[wr_bank_q][wr_cnt_q] <= bus.in_data;
    end
  end
endmodule

// File: tb/tb_fft_bitrev_stream.sv
// Bench for fft_bitrev_stream: two instances (N=16 on lane 0, N=4 on lane 1),
// randomized sample data, a frame-level reference model feeding an expected-output
// queue per lane, and a negedge monitor that compares DUT outputs against it.
module tb_fft_bitrev_stream;
  localparam int DW = 16;

  typedef struct packed {
    logic [31:0] d;
    logic        f;
    logic        l;
  } exp_t;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;
  always #5 clk = ~clk;

  fft_bitrev_stream_if #(.DATA_WIDTH(DW)) bus0 ();
  fft_bitrev_stream_if #(.DATA_WIDTH(DW)) bus1 ();

  fft_bitrev_stream #(.N(16), .DATA_WIDTH(DW)) dut16 (.clk(clk), .rst(rst0), .bus(bus0));
  fft_bitrev_stream #(.N(4),  .DATA_WIDTH(DW)) dut4  (.clk(clk), .rst(rst1), .bus(bus1));

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   nn [2] = '{16, 4};
  int   mode [2] = '{0, 0};       // out_ready: 0 low, 1 high, 2 random
  int   spos [2] = '{0, 0};       // stimulus position within frame
  int   started [2] = '{0, 0};
  int   wpos [2] = '{0, 0};       // model write position within frame
  logic err_pend [2] = '{1'b0, 1'b0};
  int   fe_seen [2] = '{0, 0};
  int   out_cnt [2] = '{0, 0};
  logic [31:0] fbuf [2][16];
  exp_t expq [2][$];

  function automatic void chk(string nm, int l, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s lane%0d got=%h expected=%h t=%0t", nm, l, got, exp, $time);
    end
  endfunction

  // Index whose binary digits are those of i read backwards, over log2(n) digits
  function automatic int rev(int i, int n);
    int lg = 0;
    int r  = 0;
    int x  = i;
    while ((1 << lg) < n) lg++;
    repeat (lg) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  always @(posedge clk) cyc++;

  // Downstream ready driver
  always @(posedge clk) begin
    #1;
    bus0.out_ready = (mode[0] == 2) ? 1'($urandom % 2) : (mode[0] == 1);
    bus1.out_ready = (mode[1] == 2) ? 1'($urandom % 2) : (mode[1] == 1);
  end

  // Monitor and reference model: at each negedge, compare current outputs with
  // the model, then advance the model by the transfers the next edge will make
  always @(negedge clk) begin
    logic r, iv, ir, il, ov, orr, of, ol, fe;
    logic [31:0] id, od;
    int   sz, held, n;
    exp_t e;
    for (int l = 0; l < 2; l++) begin
      n = nn[l];
      if (l == 0) begin
        r = rst0; iv = bus0.in_valid; ir = bus0.in_ready; il = bus0.in_last; id = bus0.in_data;
        ov = bus0.out_valid; orr = bus0.out_ready; of = bus0.out_first; ol = bus0.out_last;
        od = bus0.out_data; fe = bus0.frame_err;
      end else begin
        r = rst1; iv = bus1.in_valid; ir = bus1.in_ready; il = bus1.in_last; id = bus1.in_data;
        ov = bus1.out_valid; orr = bus1.out_ready; of = bus1.out_first; ol = bus1.out_last;
        od = bus1.out_data; fe = bus1.frame_err;
      end

      if (started[l] != 0) begin
        sz   = expq[l].size();
        held = (sz + n - 1) / n;
        chk("in_ready", l, 32'(ir), 32'(!r && held < 2));
        chk("out_valid", l, 32'(ov), 32'(held > 0));
        chk("frame_err", l, 32'(fe), 32'(err_pend[l]));
        if (fe) fe_seen[l]++;
        if (sz > 0) begin
          e = expq[l][0];
          chk("out_first", l, 32'(of), 32'(e.f));
          chk("out_last", l, 32'(ol), 32'(e.l));
          chk("out_data", l, od, e.d);
          if (ov && orr && !r) begin
            e = expq[l].pop_front();
            out_cnt[l]++;
          end
        end else begin
          chk("out_first_idle", l, 32'(of), 32'(0));
          chk("out_last_idle", l, 32'(ol), 32'(0));
        end
      end

      if (r) begin
        expq[l].delete();
        wpos[l]     = 0;
        err_pend[l] = 1'b0;
        started[l]  = 1;
      end else if (started[l] != 0) begin
        err_pend[l] = 1'b0;
        if (iv && ir) begin
          fbuf[l][wpos[l]] = id;
          err_pend[l] = (il != (wpos[l] == n - 1));
          if (wpos[l] == n - 1) begin
            for (int i = 0; i < n; i++) begin
              e.d = fbuf[l][rev(i, n)];
              e.f = (i == 0);
              e.l = (i == n - 1);
              expq[l].push_back(e);
            end
            wpos[l] = 0;
          end else begin
            wpos[l]++;
          end
        end
      end
    end
  end

  task automatic set_in(int l, logic v, logic [31:0] d, logic last);
    if (l == 0) begin
      bus0.in_valid = v; bus0.in_data = d; bus0.in_last = last;
    end else begin
      bus1.in_valid = v; bus1.in_data = d; bus1.in_last = last;
    end
  endtask

  // Present cnt samples back to back (real = base+k, random imag); in_last follows
  // the frame position except at index flip_at, where it is inverted
  task automatic send(int l, int cnt, int base, int flip_at);
    logic acc;
    logic last;
    int   budget;
    for (int k = 0; k < cnt; k++) begin
      last = ((spos[l] == nn[l] - 1) != (k == flip_at));
      set_in(l, 1'b1, {16'($urandom), 16'(base + k)}, last);
      acc    = 1'b0;
      budget = 0;
      while (!acc && budget < 300) begin
        @(negedge clk);
        acc = (l == 0) ? (bus0.in_valid && bus0.in_ready) : (bus1.in_valid && bus1.in_ready);
        @(posedge clk);
        #1;
        budget++;
      end
      chk("send_accept", l, 32'(acc), 32'(1));
      spos[l] = (spos[l] + 1) % nn[l];
    end
    set_in(l, 1'b0, '0, 1'b0);
  endtask

  task automatic wait_empty(int l, int budget);
    int b = 0;
    while (expq[l].size() != 0 && b < budget) begin
      @(posedge clk);
      b++;
    end
    @(posedge clk);
    #1;
    chk("drain", l, 32'(expq[l].size()), 32'(0));
  endtask

  initial begin
    int c0, oc, fe0;
    rst0 = 1'b1;
    rst1 = 1'b1;
    set_in(0, 1'b0, '0, 1'b0);
    set_in(1, 1'b0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst0 = 1'b0;
    rst1 = 1'b0;
    @(posedge clk);
    #1;

    // Single frame, ready high
    mode[0] = 1;
    send(0, 16, 0, -1);
    wait_empty(0, 100);

    // Four frames streamed with no gaps
    c0 = cyc;
    oc = out_cnt[0];
    send(0, 64, 0, -1);
    chk("stream_cycles", 0, 32'(cyc - c0), 32'(64));
    wait_empty(0, 100);
    chk("stream_outputs", 0, 32'(out_cnt[0] - oc), 32'(64));

    // Backpressure: two frames fill both banks
    mode[0] = 0;
    @(posedge clk);
    #1;
    send(0, 32, 100, -1);
    repeat (4) begin
      @(negedge clk);
      chk("full_stall", 0, 32'(bus0.in_ready), 32'(0));
    end
    @(posedge clk);
    #1;
    fork
      send(0, 1, 200, -1);
      begin
        repeat (4) @(posedge clk);
        mode[0] = 1;
        repeat (16) @(posedge clk);
        mode[0] = 0;
      end
    join
    mode[0] = 2;
    send(0, 15, 201, -1);
    wait_empty(0, 600);

    // Framing errors: early in_last, then missing in_last
    mode[0] = 1;
    fe0 = fe_seen[0];
    send(0, 16, 300, 9);
    send(0, 16, 400, 15);
    wait_empty(0, 100);
    chk("frame_err_count", 0, 32'(fe_seen[0] - fe0), 32'(2));

    // Reset after 7 samples, then a fresh frame
    send(0, 7, 500, -1);
    rst0 = 1'b1;
    @(posedge clk);
    #1;
    rst0 = 1'b0;
    spos[0] = 0;
    oc = out_cnt[0];
    send(0, 16, 600, -1);
    wait_empty(0, 100);
    chk("post_reset_outputs", 0, 32'(out_cnt[0] - oc), 32'(16));

    // Random ready with random data on lane 0
    mode[0] = 2;
    send(0, 48, 700, -1);
    wait_empty(0, 600);

    // N=4 instance: single frame, back-to-back, random ready
    mode[1] = 1;
    send(1, 4, 0, -1);
    wait_empty(1, 50);
    oc = out_cnt[1];
    send(1, 12, 10, -1);
    wait_empty(1, 50);
    chk("n4_outputs", 1, 32'(out_cnt[1] - oc), 32'(12));
    mode[1] = 2;
    send(1, 16, 40, -1);
    wait_empty(1, 300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fft_bitrev_stream.md
# fft_bitrev_stream

Streaming reorder controller that sits in front of the FFT datapath. It accepts complex samples one per cycle in natural order over a valid/ready handshake, buffers each N-sample frame in a ping-pong register bank, and re-emits every frame in bit-reversed index order over a second valid/ready handshake. It is the sequential counterpart of the parallel bit-reverse permutation. It lets a serial ADC/audio stream feed the FFT stages at a sustained rate of one sample per cycle.

## Interface
Parameters:
- N, 16: frame length in complex samples. Must be a power of two, ≥ 2.
- DATA_WIDTH, 16: width of each real and imaginary component.

Ports:
- clk, in, 1: single clock; all logic is on its rising edge.
- rst, in, 1: reset, synchronous, active-high.
- in_data, in, 2*DATA_WIDTH: complex sample, packed {imag, real}. Real occupies the low DATA_WIDTH bits.
- in_valid, in, 1: upstream sample present.
- in_last, in, 1: upstream marks the final sample of a frame. Used only for checking.
- in_ready, out, 1: block can accept a sample.
- out_data, out, 2*DATA_WIDTH: reordered complex sample, same packing as in_data.
- out_valid, out, 1: out_data is valid.
- out_first, out, 1: out_data is the first output sample of a frame (output index 0).
- out_last, out, 1: out_data is the final output sample of a frame (output index N-1).
- out_ready, in, 1: downstream accepts the sample.
- frame_err, out, 1: one-cycle pulse on an in_last mismatch.

## Operation
- Storage: two banks of N entries each, mem[bank][addr], with 2*DATA_WIDTH bits per entry.
- Registered state:
  - wr_bank, rd_bank (1 bit each)
  - wr_cnt, rd_cnt ($clog2(N) bits each)
  - full[1:0]
- Write side:
  - An input transfer occurs when in_valid && in_ready.
  - On a transfer, mem[wr_bank][wr_cnt] ← in_data and wr_cnt increments.
  - When wr_cnt == N-1 on a transfer: wr_cnt wraps to 0, full[wr_bank] ← 1, and wr_bank toggles.
- in_ready = !rst && !full[wr_bank].
- Read side:
  - out_valid = full[rd_bank].
  - out_data = mem[rd_bank][bitrev(rd_cnt)], where bitrev reverses the $clog2(N) bits. For N=16, the output order is 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
  - An output transfer occurs when out_valid && out_ready, and rd_cnt increments.
  - When rd_cnt == N-1 on a transfer: rd_cnt wraps to 0, full[rd_bank] ← 0, and rd_bank toggles.
- out_first = out_valid && rd_cnt == 0.
- out_last = out_valid && rd_cnt == N-1.
- Frame check: frame_err pulses for one cycle, in the cycle after an input transfer where in_last != (wr_cnt == N-1).
  - This covers both an early in_last and a missing in_last.
  - Framing is always governed by wr_cnt. The data is stored unchanged; there is no resynchronisation.
- Simultaneous events:
  - A write into one bank and a read from the other in the same cycle are both legal.
  - Setting full on one bank and clearing full on the other in the same edge are both applied.
  - The write bank and read bank are never the same full bank.
- Freeing a bank: when a read drains a bank, in_ready for that bank rises only in the next cycle, because full is registered. There is no same-cycle bypass.
- Reset (including mid-frame): wr_cnt, rd_cnt, wr_bank, rd_bank and full all go to 0. Partially written or partially read frames are discarded. mem contents are not reset.
- Backpressure stability: while out_valid && !out_ready, out_data, out_first and out_last hold stable.

## Timing
- Reset values:
  - in_ready=0 while rst is high, and 1 in the first cycle after release.
  - out_valid=0, out_first=0, out_last=0, frame_err=0.
  - out_data is X/don't-care while out_valid=0.
- Latency: if the N-th sample of a frame is accepted at edge k, then out_valid=1 with the index-0 sample from edge k onward (the next cycle).
- Throughput: with out_ready held high and in_valid held high, one sample per cycle is sustained indefinitely on both sides. There are no bubbles between frames.
- Buffering: with out_ready held low, exactly 2N samples are accepted. in_ready then drops after the 2N-th transfer.

## Test plan
- Single frame, N=16, input in_data.real = k for k = 0..15, out_ready=1:
  - out_valid rises the cycle after sample 15 is accepted.
  - Output real sequence is 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
  - out_first on the first output, out_last on the 16th.
- Continuous stream of 4 frames, in_valid=1 and out_ready=1 throughout:
  - in_ready never deasserts after reset.
  - 64 outputs are produced with no gaps, and each frame is bit-reversed correctly.
- Backpressure, out_ready=0:
  - in_ready falls after exactly 32 accepted samples.
  - Raising out_ready for 16 cycles drains frame 0. in_ready returns the cycle after out_last is accepted.
  - Random out_ready toggling keeps out_data stable while stalled.
- in_last asserted at sample 9, and missing at sample 15 of the next frame:
  - frame_err pulses once for each error.
  - Output ordering is unaffected.
- rst asserted for 1 cycle after 7 samples of frame 0, followed by a fresh full frame:
  - Only the fresh frame appears at the output, correctly reordered.
  - out_valid is 0 from the cycle after rst until that frame completes.
- Instance with N=4:
  - Input 0,1,2,3 produces output 0,2,1,3.
  - Back-to-back frames work correctly.
